// File: rtl/note_pkg.sv
// Shared constants, types and the reference-period helper for the note detector.
// Reference full periods are derived from the buzzer's base half-period table.
package note_pkg;

  localparam logic [31:0] BASE_HALF_PERIOD [1:7] = '{
    32'd381680, 32'd340136, 32'd303030, 32'd285714, 32'd255102, 32'd227273, 32'd202429
  };

  localparam logic [3:0]  NOTE_SILENCE = 4'd0;
  localparam int unsigned NUM_NOTES    = 7;
  localparam int unsigned TOL_SHIFT    = 6;

  typedef enum logic [1:0] {
    OCT_BASE = 2'd0,
    OCT_UP   = 2'd1,
    OCT_DOWN = 2'd2
  } octave_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARM    = 2'd1,
    ST_SEARCH = 2'd2,
    ST_DECIDE = 2'd3
  } state_e;

  // Full period for (note, octave); scale_shift divides the table for scaled-down clocks.
  function automatic logic [31:0] ref_period(input logic [2:0] note_idx,
                                             input octave_e oct,
                                             input int unsigned scale_shift);
    logic [31:0] full;
    full = BASE_HALF_PERIOD[note_idx] << 1;
    case (oct)
      OCT_UP:   full = full >> 1;
      OCT_DOWN: full = full << 1;
      default:  full = full;
    endcase
    return full >> scale_shift;
  endfunction

endpackage

// File: rtl/tone_edge_sync.sv
// Two-flop synchroniser for the asynchronous tone input followed by a
// registered rising-edge pulse (edge visible 3 cycles after the transition).
module tone_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic tone_in,
  output logic rise
);

  logic meta_reg;
  logic sync_reg;
  logic sync_d_reg;
  logic rise_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg   <= 1'b0;
      sync_reg   <= 1'b0;
      sync_d_reg <= 1'b0;
      rise_reg   <= 1'b0;
    end else begin
      meta_reg   <= tone_in;
      sync_reg   <= meta_reg;
      sync_d_reg <= sync_reg;
      rise_reg   <= sync_reg & ~sync_d_reg;
    end
  end

  assign rise = rise_reg;

endmodule

// File: rtl/note_detector.sv
// Measures the period of a square-wave tone, scans the 21-entry reference table
// one entry per cycle and publishes note/octave once consecutive periods agree.
module note_detector
  import note_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 100_000_000,
  parameter int unsigned CNT_W        = 22,
  parameter int unsigned MAX_PERIOD   = 2_000_000,
  parameter int unsigned STABLE_COUNT = 2,
  parameter int unsigned REF_SHIFT    = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tone_in,
  output logic [3:0] note,
  output logic       octave_up,
  output logic       octave_down,
  output logic       valid,
  output logic       note_changed
);

  localparam int unsigned      STAB_W   = $clog2(STABLE_COUNT + 1);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_PERIOD);
  localparam logic [STAB_W-1:0] STAB_TGT = STAB_W'(STABLE_COUNT);

  // CLK_HZ only documents the clock the reference table was built for.
  if (CLK_HZ == 0) begin : g_clk_hz_unset
  end

  logic              rise;
  logic              timeout;
  logic [CNT_W-1:0]  per_cnt_reg;
  logic [CNT_W-1:0]  per_cap_reg;
  state_e            state_reg;
  logic [2:0]        scan_note_reg;
  octave_e           scan_oct_reg;
  logic [3:0]        cand_note_reg;
  octave_e           cand_oct_reg;
  logic [3:0]        prev_note_reg;
  octave_e           prev_oct_reg;
  logic [STAB_W-1:0] stab_cnt_reg;
  logic [3:0]        note_reg;
  octave_e           oct_reg;
  logic              valid_reg;
  logic              note_changed_reg;

  logic [CNT_W-1:0]  ref_val;
  logic [CNT_W-1:0]  tol_val;
  logic [CNT_W-1:0]  diff_val;
  logic              hit;
  logic              last_entry;
  logic              same_cand;
  logic [STAB_W-1:0] stab_next;
  logic              load_out;

  tone_edge_sync u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .tone_in (tone_in),
    .rise    (rise)
  );

  assign timeout = (per_cnt_reg == MAX_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      per_cnt_reg <= '0;
    else if (rise)
      per_cnt_reg <= CNT_W'(1);
    else if (!timeout)
      per_cnt_reg <= per_cnt_reg + CNT_W'(1);
  end

  // Distance is taken as larger-minus-smaller so it never wraps.
  assign ref_val    = CNT_W'(ref_period(scan_note_reg, scan_oct_reg, REF_SHIFT));
  assign tol_val    = ref_val >> TOL_SHIFT;
  assign diff_val   = (per_cap_reg >= ref_val) ? (per_cap_reg - ref_val) : (ref_val - per_cap_reg);
  assign hit        = (diff_val <= tol_val);
  assign last_entry = (scan_oct_reg == OCT_DOWN) && (scan_note_reg == 3'(NUM_NOTES));

  always_comb begin
    same_cand = (cand_note_reg == prev_note_reg) && (cand_oct_reg == prev_oct_reg);
    stab_next = STAB_W'(1);
    if (same_cand)
      stab_next = (stab_cnt_reg >= STAB_TGT) ? STAB_TGT : stab_cnt_reg + STAB_W'(1);
    load_out = (stab_next >= STAB_TGT) &&
               ((cand_note_reg != note_reg) || (cand_oct_reg != oct_reg));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= ST_IDLE;
      per_cap_reg      <= '0;
      scan_note_reg    <= 3'd1;
      scan_oct_reg     <= OCT_BASE;
      cand_note_reg    <= NOTE_SILENCE;
      cand_oct_reg     <= OCT_BASE;
      prev_note_reg    <= NOTE_SILENCE;
      prev_oct_reg     <= OCT_BASE;
      stab_cnt_reg     <= '0;
      note_reg         <= NOTE_SILENCE;
      oct_reg          <= OCT_BASE;
      valid_reg        <= 1'b0;
      note_changed_reg <= 1'b0;
    end else begin
      note_changed_reg <= 1'b0;
      if (timeout) begin
        note_changed_reg <= (note_reg != NOTE_SILENCE) || (oct_reg != OCT_BASE);
        note_reg         <= NOTE_SILENCE;
        oct_reg          <= OCT_BASE;
        valid_reg        <= 1'b0;
        stab_cnt_reg     <= '0;
        cand_note_reg    <= NOTE_SILENCE;
        cand_oct_reg     <= OCT_BASE;
        prev_note_reg    <= NOTE_SILENCE;
        prev_oct_reg     <= OCT_BASE;
        state_reg        <= rise ? ST_ARM : ST_IDLE;
      end else begin
        case (state_reg)
          ST_IDLE: if (rise) state_reg <= ST_ARM;
          ST_ARM:  state_reg <= ST_ARM;
          ST_SEARCH: begin
            if (hit) begin
              cand_note_reg <= {1'b0, scan_note_reg};
              cand_oct_reg  <= scan_oct_reg;
              state_reg     <= ST_DECIDE;
            end else if (last_entry) begin
              cand_note_reg <= NOTE_SILENCE;
              cand_oct_reg  <= OCT_BASE;
              state_reg     <= ST_DECIDE;
            end else if (scan_note_reg == 3'(NUM_NOTES)) begin
              scan_note_reg <= 3'd1;
              scan_oct_reg  <= (scan_oct_reg == OCT_BASE) ? OCT_UP : OCT_DOWN;
            end else begin
              scan_note_reg <= scan_note_reg + 3'd1;
            end
          end
          ST_DECIDE: begin
            prev_note_reg <= cand_note_reg;
            prev_oct_reg  <= cand_oct_reg;
            stab_cnt_reg  <= stab_next;
            if (load_out) begin
              note_reg         <= cand_note_reg;
              oct_reg          <= cand_oct_reg;
              valid_reg        <= (cand_note_reg != NOTE_SILENCE);
              note_changed_reg <= 1'b1;
            end
            state_reg <= ST_ARM;
          end
          default: state_reg <= ST_IDLE;
        endcase
        // Any edge once armed captures a period and (re)starts the scan, aborting a search in flight.
        if (rise && (state_reg != ST_IDLE)) begin
          per_cap_reg   <= per_cnt_reg;
          scan_note_reg <= 3'd1;
          scan_oct_reg  <= OCT_BASE;
          state_reg     <= ST_SEARCH;
        end
      end
    end
  end

  assign note         = note_reg;
  assign octave_up    = (oct_reg == OCT_UP);
  assign octave_down  = (oct_reg == OCT_DOWN);
  assign valid        = valid_reg;
  assign note_changed = note_changed_reg;

endmodule

// File: tb/tb_note_detector.sv
// Directed bench for note_detector, run with the reference table divided by 512
// (REF_SHIFT=9) so periods are floor(2*base*2^oct / 512): mi=1183, mi up=591,
// mi down=2367, si=790, sol=996, fa=1116; mi window is 1183 +/- 18.
module tb_note_detector;

  localparam int MAX_P = 4000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tone_in;
  logic [3:0] note;
  logic       octave_up;
  logic       octave_down;
  logic       valid;
  logic       note_changed;
  logic [6:0] outs;

  int tests_run    = 0;
  int tests_failed = 0;
  int nc_count     = 0;

  note_detector #(
    .CLK_HZ       (100_000_000),
    .CNT_W        (22),
    .MAX_PERIOD   (MAX_P),
    .STABLE_COUNT (2),
    .REF_SHIFT    (9)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tone_in      (tone_in),
    .note         (note),
    .octave_up    (octave_up),
    .octave_down  (octave_down),
    .valid        (valid),
    .note_changed (note_changed)
  );

  always #5 clk = ~clk;

  assign outs = {note, octave_up, octave_down, valid};

  always @(negedge clk) if (note_changed === 1'b1) nc_count++;

  // Rising edges are exactly 'period' cycles apart; each call ends at a negedge.
  task automatic drive_periods(input int period, input int n);
    for (int i = 0; i < n; i++) begin
      tone_in = 1'b1;
      repeat (period / 2) @(negedge clk);
      tone_in = 1'b0;
      repeat (period - period / 2) @(negedge clk);
    end
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    tone_in = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    tone_in = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if (outs !== 7'b0000_000) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %b expected %b", outs, 7'b0000_000);
    end
    tests_run++;
    if (note_changed !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_note_changed: got %b expected 0", note_changed);
    end
    rst_n = 1'b1;
    @(negedge clk);
    $display("[TB] test_reset: note=%0d valid=%0b", note, valid);
  endtask

  task automatic test_mi_latency();
    int nc0;
    do_reset();
    nc0 = nc_count;
    drive_periods(1183, 2);
    tone_in = 1'b1;                 // third rising edge
    repeat (7) @(negedge clk);
    tests_run++;
    if (outs !== 7'b0000_000) begin
      tests_failed++;
      $display("FAIL mi_before_update: got %b expected %b", outs, 7'b0000_000);
    end
    @(negedge clk);
    tests_run++;
    if (outs !== 7'b0011_001) begin
      tests_failed++;
      $display("FAIL mi_at_update: got %b expected %b", outs, 7'b0011_001);
    end
    tests_run++;
    if (note_changed !== 1'b1) begin
      tests_failed++;
      $display("FAIL mi_pulse_high: got %b expected 1", note_changed);
    end
    @(negedge clk);
    tests_run++;
    if (note_changed !== 1'b0) begin
      tests_failed++;
      $display("FAIL mi_pulse_width: got %b expected 0", note_changed);
    end
    repeat (591 - 9) @(negedge clk);
    tone_in = 1'b0;
    repeat (592) @(negedge clk);
    drive_periods(1183, 1);
    tests_run++;
    if (outs !== 7'b0011_001 || (nc_count - nc0) !== 1) begin
      tests_failed++;
      $display("FAIL mi_hold: got outs=%b pulses=%0d expected outs=%b pulses=1", outs, nc_count - nc0, 7'b0011_001);
    end
    $display("[TB] test_mi_latency: note=%0d up=%0b down=%0b valid=%0b", note, octave_up, octave_down, valid);
  endtask

  task automatic test_octaves();
    int periods [3] = '{591, 2367, 790};
    logic [6:0] expect_outs [3] = '{7'b0011_101, 7'b0011_011, 7'b0111_001};
    string names [3] = '{"mi_up", "mi_down", "si_base"};
    int nc0;
    for (int t = 0; t < 3; t++) begin
      do_reset();
      nc0 = nc_count;
      drive_periods(periods[t], 3);
      tests_run++;
      if (outs !== expect_outs[t]) begin
        tests_failed++;
        $display("FAIL %s_outputs: got %b expected %b", names[t], outs, expect_outs[t]);
      end
      tests_run++;
      if ((nc_count - nc0) !== 1) begin
        tests_failed++;
        $display("FAIL %s_pulses: got %0d expected 1", names[t], nc_count - nc0);
      end
      $display("[TB] test_octaves %s: note=%0d up=%0b down=%0b valid=%0b", names[t], note, octave_up, octave_down, valid);
    end
  endtask

  task automatic test_tolerance();
    int nc0;
    do_reset();
    nc0 = nc_count;
    drive_periods(1201, 3);         // 1183 + 18, upper edge of the window
    tests_run++;
    if (outs !== 7'b0011_001) begin
      tests_failed++;
      $display("FAIL tol_inside: got %b expected %b", outs, 7'b0011_001);
    end
    drive_periods(1202, 3);         // one cycle outside: unknown everywhere
    tests_run++;
    if (outs !== 7'b0000_000) begin
      tests_failed++;
      $display("FAIL tol_outside: got %b expected %b", outs, 7'b0000_000);
    end
    tests_run++;
    if ((nc_count - nc0) !== 2) begin
      tests_failed++;
      $display("FAIL tol_pulses: got %0d expected 2", nc_count - nc0);
    end
    $display("[TB] test_tolerance: note=%0d valid=%0b pulses=%0d", note, valid, nc_count - nc0);
  endtask

  task automatic test_timeout();
    int nc0;
    do_reset();
    nc0 = nc_count;
    drive_periods(996, 3);
    tone_in = 1'b1;                 // last edge before silence
    repeat (498) @(negedge clk);
    tone_in = 1'b0;
    repeat (MAX_P + 3 - 498) @(negedge clk);
    tests_run++;
    if (outs !== 7'b0101_001) begin
      tests_failed++;
      $display("FAIL timeout_before: got %b expected %b", outs, 7'b0101_001);
    end
    @(negedge clk);
    tests_run++;
    if (outs !== 7'b0000_000) begin
      tests_failed++;
      $display("FAIL timeout_clear: got %b expected %b", outs, 7'b0000_000);
    end
    tests_run++;
    if (note_changed !== 1'b1) begin
      tests_failed++;
      $display("FAIL timeout_pulse: got %b expected 1", note_changed);
    end
    repeat (20) @(negedge clk);
    drive_periods(996, 2);
    tests_run++;
    if (outs !== 7'b0000_000) begin
      tests_failed++;
      $display("FAIL timeout_rearm: got %b expected %b", outs, 7'b0000_000);
    end
    tests_run++;
    if ((nc_count - nc0) !== 2) begin
      tests_failed++;
      $display("FAIL timeout_pulses: got %0d expected 2", nc_count - nc0);
    end
    $display("[TB] test_timeout: note=%0d valid=%0b pulses=%0d", note, valid, nc_count - nc0);
  endtask

  task automatic test_stability();
    int nc0;
    do_reset();
    nc0 = nc_count;
    for (int i = 0; i < 3; i++) begin
      drive_periods(1183, 1);
      drive_periods(1116, 1);
    end
    tests_run++;
    if (outs !== 7'b0000_000) begin
      tests_failed++;
      $display("FAIL stability_outputs: got %b expected %b", outs, 7'b0000_000);
    end
    tests_run++;
    if ((nc_count - nc0) !== 0) begin
      tests_failed++;
      $display("FAIL stability_pulses: got %0d expected 0", nc_count - nc0);
    end
    $display("[TB] test_stability: note=%0d pulses=%0d", note, nc_count - nc0);
  endtask

  task automatic test_reset_mid_search();
    do_reset();
    drive_periods(1183, 3);
    tests_run++;
    if (outs !== 7'b0011_001) begin
      tests_failed++;
      $display("FAIL rst_setup: got %b expected %b", outs, 7'b0011_001);
    end
    tone_in = 1'b1;
    repeat (5) @(negedge clk);      // second cycle of the table scan
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (outs !== 7'b0000_000 || note_changed !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_async: got outs=%b nc=%b expected outs=%b nc=0", outs, note_changed, 7'b0000_000);
    end
    tone_in = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    drive_periods(591, 2);
    tests_run++;
    if (outs !== 7'b0000_000) begin
      tests_failed++;
      $display("FAIL rst_rearm: got %b expected %b", outs, 7'b0000_000);
    end
    drive_periods(591, 1);
    tests_run++;
    if (outs !== 7'b0011_101) begin
      tests_failed++;
      $display("FAIL rst_redetect: got %b expected %b", outs, 7'b0011_101);
    end
    $display("[TB] test_reset_mid_search: note=%0d up=%0b valid=%0b", note, octave_up, valid);
  endtask

  initial begin
    rst_n   = 1'b0;
    tone_in = 1'b0;
    test_reset();
    test_mi_latency();
    test_octaves();
    test_tolerance();
    test_timeout();
    test_stability();
    test_reset_mid_search();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
